// File: rtl/versatile_mem_ctrl_pkg.sv
// Shared types for the phase clock generator:
// state encoding and counter width helper.
package versatile_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_LOCKING = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_DRAIN   = 2'd2
  } cpg_state_e;

  function automatic int cpg_cnt_w(
    input int div_w,
    input int num_phases
  );
    return div_w + $clog2(num_phases);
  endfunction

endpackage

// File: rtl/clk_phase_cmp.sv
// One phase slice: decides the next level of a
// clk_out bit from the shared phase counter.
module clk_phase_cmp
  import versatile_mem_ctrl_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int DIV_W      = 4,
  parameter int PHASE      = 0,
  parameter int CW         = cpg_cnt_w(DIV_W, NUM_PHASES)
) (
  input  logic [CW-1:0]    cnt_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             nxt_o,
  output logic             start_o
);

  logic [CW-1:0] d_w;
  logic [CW-1:0] per;
  logic [CW-1:0] ofs;
  logic [CW-1:0] half;
  logic [CW-1:0] diff;

  assign d_w  = CW'(div_i);
  assign per  = d_w * CW'(NUM_PHASES);
  assign ofs  = d_w * CW'(PHASE);
  assign half = per >> 1;

  // ofs < per, so one conditional add of per is a full modulo
  assign diff = (cnt_i >= ofs) ? (cnt_i - ofs)
                               : (cnt_i + per - ofs);

  assign nxt_o   = (diff < half);
  assign start_o = (cnt_i == ofs);

endmodule

// File: rtl/clk_phase_gen.sv
// Multi-phase divided clock generator with lock
// tracking and glitch-free divide changes.
module clk_phase_gen
  import versatile_mem_ctrl_pkg::*;
#(
  parameter int NUM_PHASES   = 4,
  parameter int DIV_W        = 4,
  parameter int DIV_DEFAULT  = 1,
  parameter int LOCK_PERIODS = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic [DIV_W-1:0]      div_req,
  input  logic                  div_load,
  output logic [NUM_PHASES-1:0] clk_out,
  output logic                  locked,
  output logic                  busy,
  output logic                  load_err
);

  localparam int CW = cpg_cnt_w(DIV_W, NUM_PHASES);
  localparam int WW =
    (LOCK_PERIODS < 2) ? 1 : $clog2(LOCK_PERIODS);
  localparam logic [WW-1:0] LAST_WRAP =
    WW'(LOCK_PERIODS - 1);
  localparam logic [DIV_W-1:0] DIV_RST =
    DIV_W'(DIV_DEFAULT);

  cpg_state_e state_q, state_d;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [DIV_W-1:0]      pend_q, pend_d;
  logic [NUM_PHASES-1:0] hold_q, hold_d;
  logic [NUM_PHASES-1:0] arm_q, arm_d;
  logic [WW-1:0]         wraps_q, wraps_d;
  logic [NUM_PHASES-1:0] out_q, out_d;
  logic                  locked_q;
  logic                  busy_q;
  logic                  err_q, err_d;

  logic [NUM_PHASES-1:0] nxt;
  logic [NUM_PHASES-1:0] start;
  logic [NUM_PHASES-1:0] gate;
  logic [CW-1:0]         per_cur;
  logic                  wrap;
  logic                  load_ok;
  logic                  load_bad;

  for (genvar k = 0; k < NUM_PHASES; k++) begin : g_ph
    clk_phase_cmp #(
      .NUM_PHASES(NUM_PHASES),
      .DIV_W     (DIV_W),
      .PHASE     (k),
      .CW        (CW)
    ) u_cmp (
      .cnt_i  (cnt_q),
      .div_i  (div_q),
      .nxt_o  (nxt[k]),
      .start_o(start[k])
    );
  end

  assign per_cur = CW'(div_q) * CW'(NUM_PHASES);
  assign wrap    = (cnt_q == per_cur - CW'(1));

  assign load_ok  = div_load && (div_req != '0)
                 && (state_q == ST_LOCKED);
  assign load_bad = div_load && ((div_req == '0)
                 || (state_q != ST_LOCKED));

  always_comb begin
    state_d = state_q;
    cnt_d   = wrap ? '0 : cnt_q + CW'(1);
    div_d   = div_q;
    pend_d  = pend_q;
    hold_d  = hold_q;
    arm_d   = arm_q | start;
    wraps_d = wraps_q;
    err_d   = load_bad;
    gate    = hold_q;
    unique case (1'b1)
      (state_q == ST_LOCKING): begin
        if (wrap) begin
          if (wraps_q == LAST_WRAP) begin
            state_d = ST_LOCKED;
          end else begin
            wraps_d = wraps_q + WW'(1);
          end
        end
      end
      (state_q == ST_LOCKED): begin
        if (load_ok) begin
          state_d = ST_DRAIN;
          pend_d  = div_req;
        end
      end
      (state_q == ST_DRAIN): begin
        // park a bit low at its next rise: both the last
        // high and the last low phase ran full length
        gate   = hold_q | (nxt & ~out_q);
        hold_d = gate;
        if (&gate) begin
          div_d   = pend_q;
          cnt_d   = '0;
          hold_d  = '0;
          arm_d   = '0;
          wraps_d = '0;
          state_d = ST_LOCKING;
        end
      end
      default: state_d = ST_LOCKING;
    endcase
    // a phase only emits once its own start point is seen
    out_d = nxt & arm_d & ~gate;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_LOCKING;
      cnt_q    <= '0;
      div_q    <= DIV_RST;
      pend_q   <= '0;
      hold_q   <= '0;
      arm_q    <= '0;
      wraps_q  <= '0;
      out_q    <= '0;
      locked_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      pend_q   <= pend_d;
      hold_q   <= hold_d;
      arm_q    <= arm_d;
      wraps_q  <= wraps_d;
      out_q    <= out_d;
      locked_q <= (state_d == ST_LOCKED);
      busy_q   <= (state_d == ST_DRAIN);
      err_q    <= err_d;
    end
  end

  assign clk_out  = out_q;
  assign locked   = locked_q;
  assign busy     = busy_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_clk_phase_gen.sv
// Directed bench: 4-phase instance for lock, drain,
// error and reset; 8-phase instance at max divide.
module tb_clk_phase_gen;

  logic       clk;
  logic       rst_n;
  logic [3:0] div_req;
  logic       div_load;
  logic [3:0] clk_out;
  logic       locked;
  logic       busy;
  logic       load_err;

  logic       rst8_n;
  logic [3:0] div_req8;
  logic       div_load8;
  logic [7:0] clk_out8;
  logic       locked8;
  logic       busy8;
  logic       err8;

  int checks = 0;
  int errors = 0;

  logic       mon_en;
  logic [3:0] last;
  logic [3:0] seen;
  int         run [4];

  clk_phase_gen #(
    .NUM_PHASES  (4),
    .DIV_W       (4),
    .DIV_DEFAULT (2),
    .LOCK_PERIODS(4)
  ) u4 (
    .clk_in  (clk),
    .rst_n   (rst_n),
    .div_req (div_req),
    .div_load(div_load),
    .clk_out (clk_out),
    .locked  (locked),
    .busy    (busy),
    .load_err(load_err)
  );

  clk_phase_gen #(
    .NUM_PHASES  (8),
    .DIV_W       (4),
    .DIV_DEFAULT (15),
    .LOCK_PERIODS(1)
  ) u8 (
    .clk_in  (clk),
    .rst_n   (rst8_n),
    .div_req (div_req8),
    .div_load(div_load8),
    .clk_out (clk_out8),
    .locked  (locked8),
    .busy    (busy8),
    .load_err(err8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // no pulse may be shorter than min(8/2, 12/2) = 4
  always @(negedge clk) begin
    if (!mon_en) begin
      seen = '0;
      last = clk_out;
      for (int k = 0; k < 4; k++) run[k] = 0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (clk_out[k] !== last[k]) begin
          if (seen[k]) begin
            checks++;
            assert (run[k] >= 4) else begin
              errors++;
              $error("FAIL pulse_len bit%0d observed=%0d expected>=4",
                     k, run[k]);
            end
          end
          seen[k] = 1'b1;
          run[k]  = 1;
        end else begin
          run[k]++;
        end
      end
      last = clk_out;
    end
  end

  initial begin
    rst_n     = 1'b0;
    rst8_n    = 1'b0;
    div_req   = '0;
    div_load  = 1'b0;
    div_req8  = '0;
    div_load8 = 1'b0;
    mon_en    = 1'b0;

    step(2);
    chk("rst_clk_out", 32'(clk_out), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_load_err", 32'(load_err), 32'h0);

    rst_n = 1'b1;
    step(1);
    chk("start_n1", 32'(clk_out), 32'h1);
    step(2);
    chk("start_n3", 32'(clk_out), 32'h3);
    step(2);
    chk("start_n5", 32'(clk_out), 32'h6);
    step(2);
    chk("start_n7", 32'(clk_out), 32'hc);
    step(2);
    chk("steady_n9", 32'(clk_out), 32'h9);
    mon_en = 1'b1;
    step(22);
    chk("lock_n31", 32'(locked), 32'h0);
    step(1);
    chk("lock_n32", 32'(locked), 32'h1);
    chk("busy_n32", 32'(busy), 32'h0);
    chk("out_n32", 32'(clk_out), 32'hc);

    div_req  = 4'd3;
    div_load = 1'b1;
    step(1);
    div_load = 1'b0;
    div_req  = '0;
    chk("drain_busy_n33", 32'(busy), 32'h1);
    chk("drain_lock_n33", 32'(locked), 32'h0);
    chk("drain_out_n33", 32'(clk_out), 32'h9);
    step(2);
    chk("drain_out_n35", 32'(clk_out), 32'h1);
    step(2);
    chk("drain_out_n37", 32'(clk_out), 32'h0);
    step(3);
    chk("drain_busy_n40", 32'(busy), 32'h1);
    step(1);
    chk("drain_busy_n41", 32'(busy), 32'h0);
    chk("drain_out_n41", 32'(clk_out), 32'h0);
    chk("drain_lock_n41", 32'(locked), 32'h0);
    step(1);
    chk("d3_out_n42", 32'(clk_out), 32'h1);
    step(3);
    chk("d3_out_n45", 32'(clk_out), 32'h3);
    step(2);
    chk("d3_out_n47", 32'(clk_out), 32'h3);
    step(1);
    chk("d3_out_n48", 32'(clk_out), 32'h6);
    step(6);
    chk("d3_out_n54", 32'(clk_out), 32'h9);
    step(34);
    chk("d3_lock_n88", 32'(locked), 32'h0);
    step(1);
    chk("d3_lock_n89", 32'(locked), 32'h1);

    div_req  = '0;
    div_load = 1'b1;
    step(1);
    div_load = 1'b0;
    chk("zero_err_n90", 32'(load_err), 32'h1);
    chk("zero_lock_n90", 32'(locked), 32'h1);
    chk("zero_busy_n90", 32'(busy), 32'h0);
    step(1);
    chk("zero_err_n91", 32'(load_err), 32'h0);
    step(4);
    chk("zero_b0_n95", 32'(clk_out[0]), 32'h1);
    step(1);
    chk("zero_b0_n96", 32'(clk_out[0]), 32'h0);

    div_req  = 4'd4;
    div_load = 1'b1;
    step(1);
    chk("acc_busy_n97", 32'(busy), 32'h1);
    chk("acc_err_n97", 32'(load_err), 32'h0);
    div_req = 4'd5;
    step(1);
    div_load = 1'b0;
    chk("drn_err_n98", 32'(load_err), 32'h1);
    chk("drn_busy_n98", 32'(busy), 32'h1);
    step(1);
    chk("drn_err_n99", 32'(load_err), 32'h0);
    chk("drn_busy_n99", 32'(busy), 32'h1);

    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("midrst_out", 32'(clk_out), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_lock", 32'(locked), 32'h0);
    chk("midrst_err", 32'(load_err), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("re_n1", 32'(clk_out), 32'h1);
    step(2);
    chk("re_n3", 32'(clk_out), 32'h3);
    step(2);
    chk("re_n5", 32'(clk_out), 32'h6);

    div_req  = 4'd3;
    div_load = 1'b1;
    step(1);
    div_load = 1'b0;
    chk("lkg_err_n6", 32'(load_err), 32'h1);
    chk("lkg_out_n6", 32'(clk_out), 32'h6);
    chk("lkg_busy_n6", 32'(busy), 32'h0);
    chk("lkg_lock_n6", 32'(locked), 32'h0);
    step(1);
    chk("lkg_err_n7", 32'(load_err), 32'h0);
    chk("lkg_out_n7", 32'(clk_out), 32'hc);
    step(25);
    chk("re_lock_n32", 32'(locked), 32'h1);

    div_req  = 4'd2;
    div_load = 1'b1;
    step(1);
    div_load = 1'b0;
    chk("same_busy_n33", 32'(busy), 32'h1);
    step(8);
    chk("same_busy_n41", 32'(busy), 32'h0);
    step(1);
    chk("same_out_n42", 32'(clk_out), 32'h1);
    step(2);
    chk("same_out_n44", 32'(clk_out), 32'h3);

    rst8_n = 1'b1;
    step(1);
    chk("p8_n1", 32'(clk_out8), 32'h01);
    step(14);
    chk("p8_n15", 32'(clk_out8), 32'h01);
    step(1);
    chk("p8_n16", 32'(clk_out8), 32'h03);
    step(89);
    chk("p8_n105", 32'(clk_out8), 32'h78);
    step(1);
    chk("p8_n106", 32'(clk_out8), 32'hf0);
    step(13);
    chk("p8_lock_n119", 32'(locked8), 32'h0);
    step(1);
    chk("p8_lock_n120", 32'(locked8), 32'h1);
    chk("p8_n120", 32'(clk_out8), 32'hf0);
    step(1);
    chk("p8_wrap_n121", 32'(clk_out8), 32'he1);
    chk("p8_busy", 32'(busy8), 32'h0);
    chk("p8_err", 32'(err8), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
